// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing one RAM controller command port among NCH requesters
module ram_arbiter #(
    parameter int NCH     = 2,
    parameter int DW      = 16,
    parameter int AW      = 23,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    reqInstr,
    input  logic [NCH*AW-1:0] reqAddr,
    input  logic [NCH*DW-1:0] reqData,
    output logic [NCH-1:0]    gnt,
    output logic [NCH-1:0]    done,
    output logic              err,
    output logic [DW-1:0]     rdData,
    output logic              ramInstruction,
    output logic              ramLatch,
    output logic [AW-1:0]     ramBusAddr,
    output logic [DW-1:0]     ramBusDataIn,
    input  logic [DW-1:0]     ramBusDataOut,
    input  logic              ramReady
);

    localparam int          IW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_sel;
    logic [15:0]     r_tcnt;
    logic [NCH-1:0]  w_req;
    logic [IW-1:0]   w_pick;
    logic            w_found;

    // A channel's req is still high in its own done cycle; ignore it there so it waits its turn.
    assign w_req = req & ~done;

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!w_found && w_req[(int'(r_last) + 1 + k) % NCH]) begin
                w_found = 1'b1;
                w_pick  = IW'((int'(r_last) + 1 + k) % NCH);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= S_IDLE;
            r_last         <= IW'(NCH - 1);
            r_sel          <= '0;
            r_tcnt         <= '0;
            gnt            <= '0;
            done           <= '0;
            err            <= 1'b0;
            rdData         <= '0;
            ramInstruction <= 1'b0;
            ramLatch       <= 1'b0;
            ramBusAddr     <= '0;
            ramBusDataIn   <= '0;
        end else begin
            done     <= '0;
            err      <= 1'b0;
            ramLatch <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ramReady && w_found) begin
                        gnt            <= NCH'(1) << w_pick;
                        r_sel          <= w_pick;
                        r_last         <= w_pick;
                        ramInstruction <= reqInstr[w_pick];
                        ramBusAddr     <= reqAddr[int'(w_pick)*AW +: AW];
                        ramBusDataIn   <= reqData[int'(w_pick)*DW +: DW];
                        ramLatch       <= 1'b1;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_tcnt  <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (r_tcnt == TLIM) begin
                        done    <= NCH'(1) << r_sel;
                        err     <= 1'b1;
                        gnt     <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                        if (!ramReady) r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (ramReady) begin
                        done    <= NCH'(1) << r_sel;
                        gnt     <= '0;
                        if (!ramInstruction) rdData <= ramBusDataOut;
                        r_state <= S_IDLE;
                    end else if (r_tcnt == TLIM) begin
                        done    <= NCH'(1) << r_sel;
                        err     <= 1'b1;
                        gnt     <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter with a small RAM controller model
module tb_ram_arbiter;

    localparam int NCH = 2;
    localparam int DW  = 16;
    localparam int AW  = 23;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NCH-1:0]    req = '0;
    logic [NCH-1:0]    reqInstr = '0;
    logic [NCH*AW-1:0] reqAddr = '0;
    logic [NCH*DW-1:0] reqData = '0;
    logic [NCH-1:0]    gnt;
    logic [NCH-1:0]    done;
    logic              err;
    logic [DW-1:0]     rdData;
    logic              ramInstruction;
    logic              ramLatch;
    logic [AW-1:0]     ramBusAddr;
    logic [DW-1:0]     ramBusDataIn;
    logic [DW-1:0]     ramBusDataOut = '0;
    logic              ramReady = 1'b1;

    ram_arbiter #(.NCH(NCH), .DW(DW), .AW(AW), .TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn), .req(req), .reqInstr(reqInstr), .reqAddr(reqAddr),
        .reqData(reqData), .gnt(gnt), .done(done), .err(err), .rdData(rdData),
        .ramInstruction(ramInstruction), .ramLatch(ramLatch), .ramBusAddr(ramBusAddr),
        .ramBusDataIn(ramBusDataIn), .ramBusDataOut(ramBusDataOut), .ramReady(ramReady)
    );

    always #5 clk = ~clk;

    // RAM model: ready drops one cycle after the latch and returns three cycles later.
    int   mdl_cnt = 0;
    logic rdy = 1'b1;
    logic no_drop = 1'b0;
    logic hold_low = 1'b0;
    always @(negedge clk) begin
        if (mdl_cnt != 0) begin
            if (mdl_cnt == 1) rdy = 1'b0;
            if (mdl_cnt == 4) begin
                rdy = 1'b1;
                mdl_cnt = 0;
            end else begin
                mdl_cnt++;
            end
        end else if (ramLatch && !no_drop) begin
            mdl_cnt = 1;
        end
        ramReady = hold_low ? 1'b0 : rdy;
    end

    int total = 0;
    int bad = 0;
    int lat_cnt = 0;
    int onehot_bad = 0;
    always @(negedge clk) begin
        if (ramLatch) lat_cnt++;
        if ($countones(gnt) > 1 || $countones(done) > 1) onehot_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int          lat;
    int          got;
    int          stab_bad;
    logic [22:0] g_addr;
    logic [15:0] g_data;
    logic        g_ins;
    logic [1:0]  g_gnt;
    logic [1:0]  d_val;
    logic [1:0]  d_gnt;
    logic        e_val;

    task automatic wait_done(input int budget);
        int n;
        int gat;
        n = 0; gat = -1; got = 0; stab_bad = 0; lat = -1;
        while (n < budget && got == 0) begin
            @(negedge clk);
            n++;
            if (gnt != 0) begin
                if (gat < 0) begin
                    gat = n; g_addr = ramBusAddr; g_data = ramBusDataIn;
                    g_ins = ramInstruction; g_gnt = gnt;
                end else if (ramBusAddr !== g_addr || ramBusDataIn !== g_data ||
                             ramInstruction !== g_ins || gnt !== g_gnt) begin
                    stab_bad++;
                end
            end
            if (done != 0) begin
                got = 1; d_val = done; e_val = err; d_gnt = gnt; lat = n - gat;
            end
        end
        chk("done_within_budget", got, 1);
    endtask

    task automatic set_ch(input int ch, input logic ins, input logic [22:0] a, input logic [15:0] d);
        reqInstr[ch] = ins;
        reqAddr[ch*AW +: AW] = a;
        reqData[ch*DW +: DW] = d;
    endtask

    int lc0;
    int cnt;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdData", rdData, 0);
        chk("rst_latch", ramLatch, 0);
        chk("rst_addr", ramBusAddr, 0);
        chk("rst_wdata", ramBusDataIn, 0);
        chk("rst_instr", ramInstruction, 0);
        rstn = 1'b1;
        @(negedge clk);

        set_ch(0, 1'b1, 23'h000010, 16'hA5A5);
        lc0 = lat_cnt;
        req[0] = 1'b1;
        wait_done(40);
        req[0] = 1'b0;
        chk("t1_done", d_val, 2'b01);
        chk("t1_err", e_val, 0);
        chk("t1_gnt_clear", d_gnt, 0);
        chk("t1_gnt", g_gnt, 2'b01);
        chk("t1_addr", g_addr, 23'h000010);
        chk("t1_wdata", g_data, 16'hA5A5);
        chk("t1_instr", g_ins, 1);
        chk("t1_latency", lat, 5);
        chk("t1_stable", stab_bad, 0);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);
        chk("t1_latch_count", lat_cnt - lc0, 1);

        ramBusDataOut = 16'h1234;
        set_ch(1, 1'b0, 23'h000020, 16'h0000);
        req[1] = 1'b1;
        wait_done(40);
        req[1] = 1'b0;
        chk("t2_done", d_val, 2'b10);
        chk("t2_err", e_val, 0);
        chk("t2_addr", g_addr, 23'h000020);
        chk("t2_instr", g_ins, 0);
        chk("t2_rdData", rdData, 16'h1234);

        ramBusDataOut = 16'hBEEF;
        set_ch(1, 1'b1, 23'h000030, 16'h5555);
        req[1] = 1'b1;
        wait_done(40);
        req[1] = 1'b0;
        chk("t3_done", d_val, 2'b10);
        chk("t3_rdData_held", rdData, 16'h1234);

        ramBusDataOut = 16'h4321;
        set_ch(0, 1'b1, 23'h000100, 16'h1111);
        set_ch(1, 1'b0, 23'h000200, 16'h0000);
        req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            wait_done(40);
            if (i == 5) req = 2'b00;
            chk($sformatf("rr_%0d", i), d_val, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        chk("t4_rdData", rdData, 16'h4321);

        @(negedge clk);
        no_drop = 1'b1;
        ramBusDataOut = 16'hDEAD;
        set_ch(0, 1'b0, 23'h000040, 16'h0000);
        lc0 = lat_cnt;
        req[0] = 1'b1;
        wait_done(40);
        req[0] = 1'b0;
        chk("to_done", d_val, 2'b01);
        chk("to_err", e_val, 1);
        chk("to_latency", lat, 9);
        chk("to_rdData_kept", rdData, 16'h4321);
        @(negedge clk);
        chk("to_err_pulse", err, 0);
        chk("to_done_pulse", done, 0);
        chk("to_gnt_idle", gnt, 0);
        chk("to_latch_count", lat_cnt - lc0, 1);
        no_drop = 1'b0;

        set_ch(0, 1'b1, 23'h000055, 16'h7777);
        req[0] = 1'b1;
        cnt = 0;
        while (gnt == 0 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("rs_granted", gnt, 2'b01);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        req = 2'b10;
        #1;
        chk("rs_gnt", gnt, 0);
        chk("rs_done", done, 0);
        chk("rs_err", err, 0);
        chk("rs_rdData", rdData, 0);
        chk("rs_latch", ramLatch, 0);
        chk("rs_addr", ramBusAddr, 0);
        chk("rs_wdata", ramBusDataIn, 0);
        chk("rs_instr", ramInstruction, 0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done != 0 || gnt != 0) cnt++;
        end
        chk("rs_quiet", cnt, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rs_gnt_after", gnt, 2'b10);
        wait_done(40);
        req = 2'b00;
        chk("rs_done_after", d_val, 2'b10);

        hold_low = 1'b1;
        repeat (2) @(negedge clk);
        set_ch(0, 1'b0, 23'h000066, 16'h0000);
        lc0 = lat_cnt;
        req[0] = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (gnt != 0 || ramLatch) cnt++;
        end
        chk("nr_no_grant", cnt, 0);
        chk("nr_no_latch", lat_cnt - lc0, 0);
        hold_low = 1'b0;
        wait_done(40);
        req = 2'b00;
        chk("nr_done", d_val, 2'b01);

        chk("onehot", onehot_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
